// File: rtl/square_wave_period_meter_if.sv
// Sample-in / measurement-out bundle for square_wave_period_meter.
interface square_wave_period_meter_if #(
    parameter int resolution_bits = 8,
    parameter int period_width    = 16
);
    logic [resolution_bits-1:0] wave_in;
    logic [period_width-1:0]    period_out;
    logic [period_width-1:0]    high_time_out;
    logic                       period_valid;
    logic                       no_signal;

    modport master (
        output wave_in,
        input  period_out, high_time_out, period_valid, no_signal
    );

    modport slave (
        input  wave_in,
        output period_out, high_time_out, period_valid, no_signal
    );
endinterface

// File: rtl/square_wave_period_meter.sv
// Thresholds a sample stream and measures period / high time between rising crossings.
// Optional build macro PERIOD_METER_HYSTERESIS_EN selects the two-threshold level detector.
module square_wave_period_meter #(
    parameter int                         resolution_bits = 8,
    parameter int                         period_width    = 16,
    parameter logic [resolution_bits-1:0] high_thresh     = 8'hC0,
    parameter logic [resolution_bits-1:0] low_thresh      = 8'h40
) (
    input  logic                       clk,
    input  logic                       reset,
    square_wave_period_meter_if.slave  bus
);

    typedef enum logic {SEARCH, MEASURE} state_t;

    localparam logic [period_width-1:0]    count_all_ones = '1;
    localparam logic [period_width-1:0]    count_one      = {{(period_width-1){1'b0}}, 1'b1};
    localparam logic [resolution_bits-1:0] midscale       = {1'b1, {(resolution_bits-1){1'b0}}};

    if (high_thresh < low_thresh) begin : g_bad_thresh
        $error("square_wave_period_meter: high_thresh below low_thresh");
    end

    function automatic logic [period_width-1:0] sat_inc(input logic [period_width-1:0] v);
        return (v == count_all_ones) ? v : v + count_one;
    endfunction

    state_t                  state_p0, state_nxt;
    logic                    level_p0, level_nxt;
    logic [period_width-1:0] count_p0, count_nxt;
    logic [period_width-1:0] high_cap_p0, high_cap_nxt;
    logic [period_width-1:0] period_p1, period_nxt;
    logic [period_width-1:0] high_time_p1, high_time_nxt;
    logic                    vld_p1, vld_nxt;
    logic                    no_signal_p1, no_signal_nxt;
    logic                    rise, fall;

    always_comb begin
`ifdef PERIOD_METER_HYSTERESIS_EN
        if (bus.wave_in >= high_thresh)
            level_nxt = 1'b1;
        else if (bus.wave_in < low_thresh)
            level_nxt = 1'b0;
        else
            level_nxt = level_p0;
`else
        // Comparing against midscale is the same as taking the sample MSB.
        level_nxt = (bus.wave_in >= midscale);
`endif
        rise = level_nxt & ~level_p0;
        fall = ~level_nxt & level_p0;

        state_nxt     = state_p0;
        count_nxt     = count_p0;
        high_cap_nxt  = high_cap_p0;
        period_nxt    = period_p1;
        high_time_nxt = high_time_p1;
        vld_nxt       = 1'b0;
        no_signal_nxt = no_signal_p1;

        case (state_p0)
            SEARCH: begin
                if (rise) begin
                    state_nxt = MEASURE;
                    count_nxt = count_one;
                end
            end
            MEASURE: begin
                // A rise beats the timeout, so a full-scale period is still reported.
                if (rise) begin
                    period_nxt    = count_p0;
                    high_time_nxt = high_cap_p0;
                    vld_nxt       = 1'b1;
                    no_signal_nxt = 1'b0;
                    count_nxt     = count_one;
                end else if (fall) begin
                    high_cap_nxt = count_p0;
                    count_nxt    = sat_inc(count_p0);
                end else if (count_p0 == count_all_ones) begin
                    state_nxt     = SEARCH;
                    no_signal_nxt = 1'b1;
                end else begin
                    count_nxt = sat_inc(count_p0);
                end
            end
            default: state_nxt = SEARCH;
        endcase
    end

    // Stage p0: level detector and period counter; stage p1: reported measurement.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_p0     <= SEARCH;
            level_p0     <= 1'b0;
            count_p0     <= '0;
            high_cap_p0  <= '0;
            period_p1    <= '0;
            high_time_p1 <= '0;
            vld_p1       <= 1'b0;
            no_signal_p1 <= 1'b1;
        end else begin
            state_p0     <= state_nxt;
            level_p0     <= level_nxt;
            count_p0     <= count_nxt;
            high_cap_p0  <= high_cap_nxt;
            period_p1    <= period_nxt;
            high_time_p1 <= high_time_nxt;
            vld_p1       <= vld_nxt;
            no_signal_p1 <= no_signal_nxt;
        end
    end

    assign bus.period_out    = period_p1;
    assign bus.high_time_out = high_time_p1;
    assign bus.period_valid  = vld_p1;
    assign bus.no_signal     = no_signal_p1;

endmodule

// File: tb/tb_square_wave_period_meter.sv
// Directed bench: 16-bit and 8-bit counter instances share clock, reset and stimulus.
module tb_square_wave_period_meter;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

`ifdef PERIOD_METER_HYSTERESIS_EN
    localparam int thr_high = 12;
`else
    localparam int thr_high = 8;
`endif

    square_wave_period_meter_if #(.resolution_bits(8), .period_width(16)) if16 ();
    square_wave_period_meter_if #(.resolution_bits(8), .period_width(8))  if8 ();

    square_wave_period_meter #(.resolution_bits(8), .period_width(16)) dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (if16.slave)
    );

    square_wave_period_meter #(.resolution_bits(8), .period_width(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (if8.slave)
    );

    int tests   = 0;
    int failed  = 0;
    int cyc     = 0;
    int pulses16 = 0;
    int pulses8  = 0;
    int last16  = 0;
    int prev16  = 0;
    int rise_cyc = 0;
    int saved8  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [7:0] w);
        if16.wave_in = w;
        if8.wave_in  = w;
        @(posedge clk);
        #1;
        cyc++;
        if (if16.period_valid === 1'b1) begin
            pulses16++;
            prev16 = last16;
            last16 = cyc;
        end
        if (if8.period_valid === 1'b1) pulses8++;
    endtask

    task automatic thresh_rep();
        repeat (4) step(8'hFF);
        repeat (4) step(8'h80);
        repeat (4) step(8'h50);
        repeat (4) step(8'h00);
    endtask

    initial begin
        if16.wave_in = 8'h00;
        if8.wave_in  = 8'h00;

        // Reset state
        reset = 1'b1;
        repeat (3) step(8'h00);
        reset = 1'b0;
        check("rst_period16", if16.period_out, 0);
        check("rst_high16", if16.high_time_out, 0);
        check("rst_valid16", if16.period_valid, 0);
        check("rst_nosig16", if16.no_signal, 1);
        check("rst_nosig8", if8.no_signal, 1);
        check("rst_valid8", if8.period_valid, 0);

        // 5 high / 5 low: first pulse at second rise
        pulses16 = 0;
        repeat (5) step(8'hFF);
        repeat (5) step(8'h00);
        check("sym_no_early_pulse", pulses16, 0);
        check("sym_nosig_before", if16.no_signal, 1);
        step(8'hFF);
        check("sym_first_valid", if16.period_valid, 1);
        check("sym_first_period", if16.period_out, 10);
        check("sym_first_high", if16.high_time_out, 5);
        check("sym_nosig_after", if16.no_signal, 0);
        step(8'hFF);
        check("sym_valid_single", if16.period_valid, 0);
        check("sym_period_hold", if16.period_out, 10);
        repeat (3) step(8'hFF);
        pulses16 = 0;
        repeat (3) begin
            repeat (5) step(8'h00);
            repeat (5) step(8'hFF);
        end
        check("sym_pulse_count", pulses16, 3);
        check("sym_period", if16.period_out, 10);
        check("sym_high", if16.high_time_out, 5);
        check("sym_gap", last16 - prev16, 10);

        // Transition into 3 high / 13 low
        repeat (13) step(8'h00);
        step(8'hFF);
        check("trans_period", if16.period_out, 18);
        check("trans_high", if16.high_time_out, 5);
        repeat (2) step(8'hFF);
        pulses16 = 0;
        repeat (3) begin
            repeat (13) step(8'h00);
            repeat (3) step(8'hFF);
        end
        check("asym_pulse_count", pulses16, 3);
        check("asym_period", if16.period_out, 16);
        check("asym_high", if16.high_time_out, 3);
        check("asym_gap", last16 - prev16, 16);

        // Four-level staircase
        thresh_rep();
        thresh_rep();
        pulses16 = 0;
        repeat (3) thresh_rep();
        check("stair_pulse_count", pulses16, 3);
        check("stair_period", if16.period_out, 16);
        check("stair_high", if16.high_time_out, thr_high);
        check("stair_gap", last16 - prev16, 16);

        // One-cycle reset in the low phase of 10-clock toggling
        repeat (5) step(8'hFF);
        repeat (2) step(8'h00);
        reset = 1'b1;
        step(8'h00);
        reset = 1'b0;
        check("mid_rst_period16", if16.period_out, 0);
        check("mid_rst_high16", if16.high_time_out, 0);
        check("mid_rst_valid16", if16.period_valid, 0);
        check("mid_rst_nosig16", if16.no_signal, 1);
        check("mid_rst_period8", if8.period_out, 0);
        check("mid_rst_nosig8", if8.no_signal, 1);
        pulses16 = 0;
        repeat (2) step(8'h00);
        repeat (5) step(8'hFF);
        repeat (5) step(8'h00);
        check("mid_rst_no_pulse", pulses16, 0);
        check("mid_rst_nosig_held", if16.no_signal, 1);
        step(8'hFF);
        rise_cyc = cyc;
        check("mid_rst_valid", if16.period_valid, 1);
        check("mid_rst_period", if16.period_out, 10);
        check("mid_rst_high", if16.high_time_out, 5);
        check("mid_rst_period8_after", if8.period_out, 10);

        // Timeout on the 8-bit instance: 255 clocks after the last rise
        repeat (4) step(8'hFF);
        saved8 = pulses8;
        repeat (250) step(8'h00);
        check("to_cycle_index", cyc - rise_cyc, 254);
        check("to_nosig8_before", if8.no_signal, 0);
        step(8'h00);
        check("to_nosig8", if8.no_signal, 1);
        check("to_valid8", if8.period_valid, 0);
        check("to_period8_hold", if8.period_out, 10);
        check("to_high8_hold", if8.high_time_out, 5);
        check("to_no_pulse8", pulses8, saved8);
        check("to_nosig16_still0", if16.no_signal, 0);
        repeat (5) step(8'hFF);
        check("to_resume_no_pulse", pulses8, saved8);
        check("to_resume_nosig8", if8.no_signal, 1);
        repeat (5) step(8'h00);
        step(8'hFF);
        check("to_resume_valid8", if8.period_valid, 1);
        check("to_resume_period8", if8.period_out, 10);
        check("to_resume_high8", if8.high_time_out, 5);
        check("to_resume_nosig8_clear", if8.no_signal, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/square_wave_period_meter.md
# square_wave_period_meter

Receive-side measurement block for the synthesizer's waveform path. It takes an unsigned sample stream such as the 8-bit square-wave generator output and thresholds it into a logic level. It then counts clock cycles between rising crossings and reports period and high time with a one-cycle valid pulse. It sits after the generator in the audio chain, as a self-check and as a frequency-readback source for control logic.

## Interface
- resolution_bits, 8: width of sample input.
- period_width, 16: width of the period and high-time counters/outputs.
- high_thresh, 8'hC0: level goes 1 when sample >= high_thresh (hysteresis build only).
- low_thresh, 8'h40: level goes 0 when sample < low_thresh (hysteresis build only).
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- wave_in  input  resolution_bits  unsigned sample, sampled every clk edge.
- period_out  output  period_width  clocks between the last two rising crossings.
- high_time_out  output  period_width  clocks the level was 1 within the reported period.
- period_valid  output  1  one-cycle pulse when period_out/high_time_out update.
- no_signal  output  1  high while no complete period has been measured since reset or since the last timeout.

## Operation
- Level register `level`, updated every edge from wave_in. Exact rule is set by the macro; see Configuration.
- Rise event at an edge: the level goes 0->1 at that edge. Fall event: the level goes 1->0.
- Counter `count` is period_width bits, with states SEARCH and MEASURE.
- SEARCH:
  - Count is idle.
  - On a rise event, go to MEASURE with count <= 1.
  - No output changes.
- MEASURE, each edge:
  - Rise event: period_out <= count, high_time_out <= captured high value, period_valid <= 1, no_signal <= 0, count <= 1.
  - Fall event: capture high value <= count, then count <= count+1.
  - Otherwise, if count == all-ones: go to SEARCH, no_signal <= 1, period_valid stays 0, period_out and high_time_out hold.
  - Otherwise: count <= count+1.
- Simultaneous rise event and count == all-ones: the rise wins; the period is reported as all-ones.
- Outputs hold their last values between pulses. period_valid is never high two edges in a row unless the period is 1, which is impossible because a period needs a fall.
- Arithmetic is unsigned. The counter never wraps; it saturates into the timeout path.

## Timing
- Reset values: period_out 0, high_time_out 0, period_valid 0, no_signal 1, level 0, count 0, state SEARCH.
- Reset asserted mid-measurement discards the partial count. The next reported period needs two fresh rise events.
- Latency: a rising crossing sample present at edge k produces period_valid high for exactly the cycle after edge k.
- Periodic input with H clocks at/above threshold and L clocks below gives period_out = H+L and high_time_out = H.
- The first valid period comes at the second rise event after reset or timeout.
- Timeout: 2^period_width − 1 clocks without a rise event after the last rise.

## Configuration
- PERIOD_METER_HYSTERESIS_EN defined:
  - level <= 1 if wave_in >= high_thresh.
  - level <= 0 if wave_in < low_thresh.
  - Otherwise level holds.
- Undefined:
  - level <= wave_in[resolution_bits-1], i.e. a midscale threshold.
  - high_thresh and low_thresh are ignored.

## Test plan
- Reset, then wave_in alternating 5 clocks 8'hFF / 5 clocks 8'h00 -> first pulse after second rise; every 10 clocks period_valid=1, period_out=10, high_time_out=5, no_signal falls to 0.
- Asymmetric 3 clocks 8'hFF / 13 clocks 8'h00 -> period_out=16, high_time_out=3 on every pulse.
- period_width=8, wave_in held 8'h00 after valid periods -> 255 clocks after last rise no_signal=1, outputs hold, no pulse; resume toggling -> pulse at second rise.
- Hysteresis build, input 8'hFF,8'h80,8'h50,8'h00 repeated with 4 clocks per value -> period_out=16, high_time_out=12. Non-hysteresis build, same input -> period_out=16, high_time_out=8.
- Assert reset for one cycle mid-period during 10-clock toggling -> all outputs at reset values, no_signal=1, next pulse period_out=10 only after two rises.
